// File: rtl/lm75_temp_to_bcd.sv
// LM75 9-bit temperature word to sign/hundreds/tens/ones/tenths digit codes.
// Iterative double-dabble conversion, one bit per clock, fixed 9-clock latency.
module lm75_temp_to_bcd #(
   parameter bit BLANK_LEAD = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [8:0] temp_raw,
   output logic       busy,
   output logic       done,
   output logic [3:0] dig_sign,
   output logic [3:0] dig_hund,
   output logic [3:0] dig_tens,
   output logic [3:0] dig_ones,
   output logic [3:0] dig_frac
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t      state, state_n;
   logic [8:0]  mag;
   logic [7:0]  bin;
   logic [11:0] bcd;
   logic [11:0] bcd_adj;
   logic [2:0]  cnt;
   logic        neg;
   logic        frac;
   logic        hund_z;
   logic        tens_z;
   logic [3:0]  hund_d;
   logic [3:0]  tens_d;

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   // 0x100 negates to itself, which read unsigned is the wanted 256
   assign mag     = temp_raw[8] ? (~temp_raw + 9'd1) : temp_raw;
   assign bcd_adj = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
   assign hund_z  = (bcd[11:8] == 4'd0);
   assign tens_z  = hund_z && (bcd[7:4] == 4'd0);
   assign hund_d  = (BLANK_LEAD && hund_z) ? 4'hF : bcd[11:8];
   assign tens_d  = (BLANK_LEAD && tens_z) ? 4'hF : bcd[7:4];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (start) state_n = SHIFT;
         SHIFT:   if (cnt == 3'd7) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin      <= '0;
         bcd      <= '0;
         cnt      <= '0;
         neg      <= 1'b0;
         frac     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         dig_sign <= 4'hF;
         dig_hund <= 4'hF;
         dig_tens <= 4'hF;
         dig_ones <= 4'hF;
         dig_frac <= 4'hF;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  bin  <= mag[8:1];
                  frac <= mag[0];
                  neg  <= temp_raw[8];
                  bcd  <= '0;
                  cnt  <= '0;
                  busy <= 1'b1;
               end
            end
            SHIFT: begin
               {bcd, bin} <= {bcd_adj[10:0], bin, 1'b0};
               cnt        <= cnt + 3'd1;
            end
            DONE: begin
               dig_sign <= neg ? 4'hA : 4'hF;
               dig_hund <= hund_d;
               dig_tens <= tens_d;
               dig_ones <= bcd[3:0];
               dig_frac <= frac ? 4'd5 : 4'd0;
               done     <= 1'b1;
               busy     <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lm75_temp_to_bcd.sv
// Bench for lm75_temp_to_bcd: directed spec cases plus random words
// against an arithmetic temperature-to-digits model.
module tb_lm75_temp_to_bcd;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [8:0] temp_raw;
   logic       busy, done, busy0, done0;
   logic [3:0] s1, h1, t1, o1, f1;
   logic [3:0] s0, h0, t0, o0, f0;
   int         n_tests = 0;
   int         n_fail  = 0;

   always #5 clk = ~clk;

   lm75_temp_to_bcd #(.BLANK_LEAD(1'b1)) u_dut (
      .clk(clk), .rst(rst), .start(start), .temp_raw(temp_raw),
      .busy(busy), .done(done),
      .dig_sign(s1), .dig_hund(h1), .dig_tens(t1),
      .dig_ones(o1), .dig_frac(f1)
   );

   lm75_temp_to_bcd #(.BLANK_LEAD(1'b0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start), .temp_raw(temp_raw),
      .busy(busy0), .done(done0),
      .dig_sign(s0), .dig_hund(h0), .dig_tens(t0),
      .dig_ones(o0), .dig_frac(f0)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Temperature in half degrees -> displayed digits
   function automatic logic [19:0] model(input logic [8:0] t,
                                         input bit blank);
      int v, m, ip, h, te, o;
      logic [3:0] sd, hd, td, fd;
      v  = $signed(t);
      m  = (v < 0) ? -v : v;
      ip = m / 2;
      h  = ip / 100;
      te = (ip / 10) % 10;
      o  = ip % 10;
      sd = (v < 0) ? 4'hA : 4'hF;
      hd = (blank && h == 0) ? 4'hF : 4'(h);
      td = (blank && h == 0 && te == 0) ? 4'hF : 4'(te);
      fd = (m % 2 == 1) ? 4'd5 : 4'd0;
      return {sd, hd, td, 4'(o), fd};
   endfunction

   function automatic logic [19:0] dig1();
      return {s1, h1, t1, o1, f1};
   endfunction

   function automatic logic [19:0] dig0();
      return {s0, h0, t0, o0, f0};
   endfunction

   task automatic wait_done(output int lat);
      lat = 0;
      while (!done && lat < 20) begin
         @(posedge clk); #1 lat++;
      end
   endtask

   task automatic check_result(input string tag, input logic [8:0] t);
      chk({tag, "_dig"},  dig1(), model(t, 1'b1));
      chk({tag, "_dig0"}, dig0(), model(t, 1'b0));
      chk({tag, "_done0"}, done0, 1'b1);
   endtask

   task automatic convert(input logic [8:0] t, input string tag);
      int lat;
      @(negedge clk);
      temp_raw = t;
      start    = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      temp_raw = 9'($urandom);
      chk({tag, "_busy"}, busy, 1'b1);
      wait_done(lat);
      chk({tag, "_lat"}, lat, 9);
      chk({tag, "_busy_end"}, busy, 1'b0);
      check_result(tag, t);
      @(posedge clk); #1;
      chk({tag, "_pulse"}, done, 1'b0);
   endtask

   initial begin
      int lat, cnt;
      logic [8:0] r;
      rst      = 1'b1;
      start    = 1'b0;
      temp_raw = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_dig", dig1(), 20'hFFFFF);
      @(negedge clk) rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("hold_dig", dig1(), 20'hFFFFF);
      chk("hold_busy", busy, 1'b0);

      convert(9'h032, "p25");
      chk("p25_const", dig1(), 20'hFF250);
      chk("p25_bl0", dig0(), 20'hF0250);
      repeat (3) @(posedge clk);
      #1;
      chk("p25_hold", dig1(), 20'hFF250);

      // reset in idle clears the held result
      @(negedge clk) rst = 1'b1;
      #1;
      chk("idle_rst_dig", dig1(), 20'hFFFFF);
      @(negedge clk) rst = 1'b0;

      convert(9'h0FA, "p125");
      chk("p125_const", dig1(), 20'hF1250);
      convert(9'h000, "zero");
      chk("zero_const", dig1(), 20'hFFF00);
      convert(9'h1FF, "m0_5");
      chk("m0_5_const", dig1(), 20'hAFF05);
      convert(9'h192, "m55");
      chk("m55_const", dig1(), 20'hAF550);
      convert(9'h100, "m128");
      chk("m128_const", dig1(), 20'hA1280);

      // start during a conversion is ignored
      @(negedge clk);
      temp_raw = 9'h032;
      start    = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      temp_raw = 9'h0FA;
      start    = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done(lat);
      chk("ign_lat", lat + 3, 9);
      chk("ign_dig", dig1(), 20'hFF250);
      cnt = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done) cnt++;
      end
      chk("ign_no_extra", cnt, 0);

      // start held through done: back-to-back every 10 clocks
      @(negedge clk);
      temp_raw = 9'h032;
      start    = 1'b1;
      @(posedge clk); #1 temp_raw = 9'h0FA;
      wait_done(lat);
      chk("b2b_lat1", lat, 9);
      chk("b2b_dig1", dig1(), 20'hFF250);
      @(posedge clk); #1 start = 1'b0;
      chk("b2b_busy2", busy, 1'b1);
      wait_done(lat);
      chk("b2b_gap", lat + 1, 10);
      chk("b2b_dig2", dig1(), 20'hF1250);
      repeat (2) @(posedge clk);

      // reset in the middle of SHIFT aborts
      @(negedge clk);
      temp_raw = 9'h032;
      start    = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      #1;
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_dig", dig1(), 20'hFFFFF);
      @(negedge clk) rst = 1'b0;
      cnt = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done) cnt++;
      end
      chk("abort_no_done", cnt, 0);
      convert(9'h033, "p25_5");
      chk("p25_5_const", dig1(), 20'hFF255);

      for (int i = 0; i < 40; i++) begin
         r = 9'($urandom);
         convert(r, $sformatf("rnd%0d_%03h", i, r));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
